nx_node_ram_arbiter: RTL and testbench
======================================

Name: nx_node_ram_arbiter

Overview:
- Shares the single read/write port B of a node's data RAM between two requesters: the message decoder (data-load writes) and the execution core (reads and writes).
- Decoder writes are buffered in a small in-order write queue. The core has priority, bounded by a starvation limit.
- A read-after-write hazard check keeps core reads coherent with queued writes.
- Sits between nx_node_decoder / nx_node_core and the data nx_ram, freeing port A for other use.

Parameters:
- ADDR_W, 10, RAM address width
- DATA_W, 32, RAM data width; strobe is bit-granular (DATA_W bits)
- WQ_DEPTH, 4, write-queue entries; power of two, >= 2
- STARVE_LIMIT, 8, consecutive core wins allowed while the queue is non-empty before one queue drain is forced; >= 1

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-low
- i_dec_addr  in  ADDR_W  decoder write address
- i_dec_wr_data  in  DATA_W  decoder write data
- i_dec_wr_strb  in  DATA_W  decoder bit write-enables
- i_dec_valid  in  1  decoder write request
- o_dec_ready  out  1  queue can accept
- i_core_addr  in  ADDR_W  core address
- i_core_wr_data  in  DATA_W  core write data
- i_core_wr_strb  in  DATA_W  core bit write-enables
- i_core_rd_en  in  1  core read request
- o_core_grant  out  1  core access performed this cycle
- o_core_rd_data  out  DATA_W  read data
- o_core_rd_valid  out  1  o_core_rd_data valid
- o_ram_addr  out  ADDR_W  RAM address
- o_ram_wr_data  out  DATA_W  RAM write data
- o_ram_wr_strb  out  DATA_W  RAM bit write-enables
- o_ram_en  out  1  RAM port enable
- i_ram_rd_data  in  DATA_W  RAM read data, valid one cycle after o_ram_en with zero strobe
- o_idle  out  1  no queued or in-flight work

Behaviour:
- Reset (i_rst==0 at posedge):
  - queue emptied, starve_cnt=0, rd_pend=0.
  - Outputs during and after reset: o_ram_en=0, o_core_grant=0, o_core_rd_valid=0, o_idle=1. o_dec_ready=1 after reset; it is 0 while reset is asserted.
  - Reset mid-operation discards queued writes and in-flight reads; no RAM write occurs after the reset edge.
- Core request: core_req = i_core_rd_en | (|i_core_wr_strb). A read with nonzero strobe is a write. The core holds the request until o_core_grant.
- Hazard: i_core_addr equals the address of any valid queue entry.
- Selection (combinational, per cycle):
  - core wins if core_req & !hazard & !(starve_cnt==STARVE_LIMIT & queue non-empty);
  - else, if the queue is non-empty, drain the head;
  - else idle.
- On a core win: o_core_grant=1; RAM driven with the core addr/data/strb; o_ram_en=1.
- On a drain: RAM driven with the head entry; o_ram_en=1; pop.
- When idle: o_ram_en=0, strb=0.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - +1 on a core win while the queue is non-empty, saturating;
  - cleared on any drain or whenever the queue is empty.
- Queue:
  - o_dec_ready = !full, registered-free.
  - Push on i_dec_valid & o_dec_ready & (|i_dec_wr_strb). Valid with zero strobe is accepted and dropped.
  - Push and pop in the same cycle are both honoured. A full queue does not accept, even if popping that cycle.
  - Read/write pointers wrap modulo WQ_DEPTH; a count register distinguishes full from empty.
  - An entry pushed in cycle N is not hazard-checked in cycle N. A core access granted in cycle N is ordered before that write.
  - Earliest drain of a pushed entry is cycle N+1.
- Reads:
  - rd_pend <= granted core read (zero strobe).
  - o_core_rd_valid = rd_pend (registered). o_core_rd_data = i_ram_rd_data (passthrough, 1-cycle latency). o_core_rd_data is don't-care when not valid.
  - Back-to-back granted reads yield back-to-back valids.
- o_idle is registered: <= queue empty & !rd_pend & !i_dec_valid & !core_req.

Test Plan:
- Reset then 4 decoder writes (addr 0..3, data 0xA0..0xA3, strb all-ones) with core idle -> RAM writes on cycles 1..4 in order; o_dec_ready stays 1; o_idle returns to 1.
- 5 decoder writes back-to-back while the core reads continuously from addr 0x100 -> 5th write stalls (o_dec_ready=0 with 4 queued). The core is granted 8 cycles, then 1 forced drain, repeating; all writes land within 45 cycles.
- Queue holds a write to 0x3 (data 0x55); core reads 0x3 -> o_core_grant=0 until the entry drains. The read then returns 0x55 with o_core_rd_valid exactly one cycle after the grant.
- Decoder push to 0x7 and core write to 0x7 in the same cycle -> core write first, queued write second; final RAM[0x7] = decoder data.
- Decoder valid with strb=0 -> accepted (ready=1), no RAM access, queue count unchanged.
- Assert i_rst=0 with 3 entries queued and a read granted the prior cycle -> after the reset edge o_ram_en=0 and o_core_rd_valid=0; the 3 queued writes never reach RAM; o_idle=1.

Source files
------------

// File: rtl/nx_node_ram_arbiter_if.sv
// Bundle of decoder, core and RAM port-B signals around nx_node_ram_arbiter.
// master = requesters plus RAM (the surrounding node), slave = the arbiter.
interface nx_node_ram_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] dec_addr;
  logic [DATA_W-1:0] dec_wr_data;
  logic [DATA_W-1:0] dec_wr_strb;
  logic              dec_valid;
  logic              dec_ready;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wr_data;
  logic [DATA_W-1:0] core_wr_strb;
  logic              core_rd_en;
  logic              core_grant;
  logic [DATA_W-1:0] core_rd_data;
  logic              core_rd_valid;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wr_data;
  logic [DATA_W-1:0] ram_wr_strb;
  logic              ram_en;
  logic [DATA_W-1:0] ram_rd_data;
  logic              idle;

  modport master (
    output dec_addr, dec_wr_data, dec_wr_strb, dec_valid,
    input  dec_ready,
    output core_addr, core_wr_data, core_wr_strb, core_rd_en,
    input  core_grant, core_rd_data, core_rd_valid,
    input  ram_addr, ram_wr_data, ram_wr_strb, ram_en,
    output ram_rd_data,
    input  idle
  );

  modport slave (
    input  dec_addr, dec_wr_data, dec_wr_strb, dec_valid,
    output dec_ready,
    input  core_addr, core_wr_data, core_wr_strb, core_rd_en,
    output core_grant, core_rd_data, core_rd_valid,
    output ram_addr, ram_wr_data, ram_wr_strb, ram_en,
    input  ram_rd_data,
    output idle
  );
endinterface

// File: rtl/nx_node_ram_arbiter.sv
// Shares data-RAM port B between the decoder (queued writes) and the core
// (priority reads/writes), with starvation bound and read-after-write hazard check.
module nx_node_ram_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int WQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic                 i_clk,
  input logic                 i_rst,
  nx_node_ram_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(WQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {SEL_IDLE, SEL_CORE, SEL_DRAIN} sel_e;

  logic [ADDR_W-1:0] q_addr [WQ_DEPTH];
  logic [DATA_W-1:0] q_data [WQ_DEPTH];
  logic [DATA_W-1:0] q_strb [WQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, offs;
  logic [CNT_W-1:0]  count;
  logic [SC_W-1:0]   starve_cnt;
  logic              rd_pend, idle_q;
  logic              core_req, hazard, q_empty, q_full, forced, push, pop;
  sel_e              sel;

  assign q_empty  = (count == '0);
  assign q_full   = (count == CNT_W'(WQ_DEPTH));
  assign core_req = bus.core_rd_en | (|bus.core_wr_strb);
  assign forced   = (starve_cnt == SC_W'(STARVE_LIMIT)) & ~q_empty;

  // Slot i holds a live entry when its distance from the head is below count.
  always_comb begin
    hazard = 1'b0;
    offs   = '0;
    for (int unsigned i = 0; i < WQ_DEPTH; i++) begin
      offs = PTR_W'(i) - rd_ptr;
      if ((CNT_W'(offs) < count) && (q_addr[i] == bus.core_addr)) hazard = 1'b1;
    end
  end

  always_comb begin
    sel = SEL_IDLE;
    if (i_rst) begin
      if (core_req && !hazard && !forced) sel = SEL_CORE;
      else if (!q_empty)                  sel = SEL_DRAIN;
    end
  end

  assign pop           = (sel == SEL_DRAIN);
  assign bus.dec_ready = i_rst & ~q_full;
  assign push          = bus.dec_valid & bus.dec_ready & (|bus.dec_wr_strb);

  always_comb begin
    bus.ram_addr    = '0;
    bus.ram_wr_data = '0;
    bus.ram_wr_strb = '0;
    bus.ram_en      = 1'b0;
    bus.core_grant  = 1'b0;
    case (sel)
      SEL_CORE: begin
        bus.ram_addr    = bus.core_addr;
        bus.ram_wr_data = bus.core_wr_data;
        bus.ram_wr_strb = bus.core_wr_strb;
        bus.ram_en      = 1'b1;
        bus.core_grant  = 1'b1;
      end
      SEL_DRAIN: begin
        bus.ram_addr    = q_addr[rd_ptr];
        bus.ram_wr_data = q_data[rd_ptr];
        bus.ram_wr_strb = q_strb[rd_ptr];
        bus.ram_en      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      q_addr[wr_ptr] <= bus.dec_addr;
      q_data[wr_ptr] <= bus.dec_wr_data;
      q_strb[wr_ptr] <= bus.dec_wr_strb;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      rd_pend    <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (pop || q_empty)
        starve_cnt <= '0;
      else if (sel == SEL_CORE && starve_cnt != SC_W'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
      rd_pend <= (sel == SEL_CORE) & ~(|bus.core_wr_strb);
      idle_q  <= q_empty & ~rd_pend & ~bus.dec_valid & ~core_req;
    end
  end

  // Registered status is masked while reset is held so outputs read as reset values.
  assign bus.core_rd_valid = rd_pend & i_rst;
  assign bus.core_rd_data  = bus.ram_rd_data;
  assign bus.idle          = idle_q | ~i_rst;
endmodule

// File: tb/tb_nx_node_ram_arbiter.sv
// Self-checking bench: per-cycle comparison of the arbiter against a queue-based
// reference model, plus directed scenarios and randomized mixed traffic.
module tb_nx_node_ram_arbiter;
  localparam int AW = 10, DW = 32, DEPTH = 4, SL = 8;
  localparam int VW = 5 + AW + 3 * DW;
  localparam logic [AW-1:0] ZA = '0;
  localparam logic [DW-1:0] ZD = '0;
  typedef logic [VW-1:0] vec_t;
  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d; logic [DW-1:0] s;} wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nx_node_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  nx_node_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WQ_DEPTH(DEPTH), .STARVE_LIMIT(SL))
    dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  int checks = 0, failures = 0;
  vec_t exp_v, act_v;

  function automatic logic [DW-1:0] init_val(int a);
    return DW'(32'h5A00_0000 + a * 32'h0001_0003);
  endfunction

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] d, logic [DW-1:0] s);
    return (old & ~s) | (d & s);
  endfunction

  // Behavioural RAM on port B
  logic [DW-1:0] ram [1<<AW];
  logic [DW-1:0] ram_q;
  bit ram_init = 1'b0;
  int unsigned ram_writes;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= init_val(i);
      ram_writes <= 0;
      ram_init <= 1'b1;
    end else if (bus.ram_en) begin
      if (bus.ram_wr_strb != '0) begin
        ram[bus.ram_addr] <= merge(ram[bus.ram_addr], bus.ram_wr_data, bus.ram_wr_strb);
        ram_writes <= ram_writes + 1;
      end else begin
        ram_q <= ram[bus.ram_addr];
      end
    end
  end
  assign bus.ram_rd_data = ram_q;

  // Reference model
  wr_t wq[$];
  int starve = 0;
  bit m_rdpend = 1'b0, m_idle = 1'b1;
  logic [DW-1:0] m_rdexp = '0;
  logic [DW-1:0] mem [1<<AW];
  bit e_win, e_drain;

  function automatic vec_t model_eval();
    bit creq, haz, forced, en;
    wr_t sel;
    creq = bus.core_rd_en || (bus.core_wr_strb != '0);
    haz = 1'b0;
    foreach (wq[i]) if (wq[i].a == bus.core_addr) haz = 1'b1;
    forced  = (starve == SL) && (wq.size() != 0);
    e_win   = rst && creq && !haz && !forced;
    e_drain = rst && !e_win && (wq.size() != 0);
    sel.a = ZA; sel.d = ZD; sel.s = ZD;
    if (e_win) begin
      sel.a = bus.core_addr; sel.d = bus.core_wr_data; sel.s = bus.core_wr_strb;
    end else if (e_drain) begin
      sel = wq[0];
    end
    en = e_win || e_drain;
    return {en, e_win, rst && (wq.size() < DEPTH), rst && m_rdpend, !rst || m_idle,
            sel.s, sel.a, sel.d, (rst && m_rdpend) ? m_rdexp : ZD};
  endfunction

  function automatic vec_t observed();
    return {bus.ram_en, bus.core_grant, bus.dec_ready, bus.core_rd_valid, bus.idle,
            bus.ram_wr_strb, bus.ram_en ? bus.ram_addr : ZA, bus.ram_en ? bus.ram_wr_data : ZD,
            bus.core_rd_valid ? bus.core_rd_data : ZD};
  endfunction

  function automatic void model_commit();
    bit creq;
    int n;
    if (!rst) begin
      wq.delete(); starve = 0; m_rdpend = 1'b0; m_idle = 1'b1;
      return;
    end
    creq = bus.core_rd_en || (bus.core_wr_strb != '0);
    n = wq.size();
    m_idle = (n == 0) && !m_rdpend && !bus.dec_valid && !creq;
    m_rdpend = e_win && (bus.core_wr_strb == '0);
    if (e_win) begin
      if (bus.core_wr_strb != '0) mem[bus.core_addr] = merge(mem[bus.core_addr], bus.core_wr_data, bus.core_wr_strb);
      else m_rdexp = mem[bus.core_addr];
    end
    if (e_drain) begin
      mem[wq[0].a] = merge(mem[wq[0].a], wq[0].d, wq[0].s);
      void'(wq.pop_front());
    end
    if (e_drain || n == 0) starve = 0;
    else if (e_win && starve < SL) starve++;
    if (bus.dec_valid && n < DEPTH && bus.dec_wr_strb != '0)
      wq.push_back('{a: bus.dec_addr, d: bus.dec_wr_data, s: bus.dec_wr_strb});
  endfunction

  task automatic drive_idle();
    bus.dec_valid = 1'b0; bus.dec_addr = '0; bus.dec_wr_data = '0; bus.dec_wr_strb = '0;
    bus.core_rd_en = 1'b0; bus.core_addr = '0; bus.core_wr_data = '0; bus.core_wr_strb = '0;
  endtask

  task automatic test_reset();
    for (int cyc = 0; cyc < 5; cyc++) begin
      drive_idle();
      rst = (cyc >= 3);
      if (cyc < 3) begin
        bus.dec_valid = 1'b1; bus.dec_wr_strb = '1; bus.dec_addr = AW'($urandom);
        bus.core_rd_en = 1'b1; bus.core_addr = AW'($urandom);
      end
      #1; exp_v = model_eval(); act_v = observed(); checks++;
      if (act_v !== exp_v) begin failures++; $display("FAIL reset cyc=%0d act=%h exp=%h", cyc, act_v, exp_v); end
      model_commit(); @(negedge clk);
    end
  endtask

  task automatic test_fill();
    for (int cyc = 0; cyc < 8; cyc++) begin
      drive_idle();
      if (cyc < 4) begin
        bus.dec_valid = 1'b1; bus.dec_addr = AW'(cyc);
        bus.dec_wr_data = DW'(32'hA0 + cyc); bus.dec_wr_strb = '1;
      end
      #1; exp_v = model_eval(); act_v = observed(); checks++;
      if (act_v !== exp_v) begin failures++; $display("FAIL fill cyc=%0d act=%h exp=%h", cyc, act_v, exp_v); end
      model_commit(); @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ram[i] !== DW'(32'hA0 + i)) begin
        failures++; $display("FAIL fill_ram addr=%0d act=%h exp=%h", i, ram[i], DW'(32'hA0 + i));
      end
    end
    checks++;
    if (bus.idle !== 1'b1) begin failures++; $display("FAIL fill_idle act=%b exp=1", bus.idle); end
  endtask

  task automatic test_starvation();
    int pushes = 0;
    bit saw_stall = 1'b0;
    int unsigned w0 = ram_writes;
    for (int cyc = 0; cyc < 54; cyc++) begin
      drive_idle();
      if (cyc < 50) begin
        bus.core_rd_en = 1'b1; bus.core_addr = AW'(12'h100);
        if (pushes < 5) begin
          bus.dec_valid = 1'b1; bus.dec_addr = AW'(8'h10 + pushes);
          bus.dec_wr_data = DW'($urandom); bus.dec_wr_strb = '1;
        end
      end
      #1; exp_v = model_eval(); act_v = observed(); checks++;
      if (act_v !== exp_v) begin failures++; $display("FAIL starve cyc=%0d act=%h exp=%h", cyc, act_v, exp_v); end
      if (bus.dec_valid && !bus.dec_ready) saw_stall = 1'b1;
      if (bus.dec_valid && rst && wq.size() < DEPTH) pushes++;
      model_commit(); @(negedge clk);
    end
    checks++;
    if (ram_writes - w0 != 5) begin failures++; $display("FAIL starve_writes act=%0d exp=5", ram_writes - w0); end
    checks++;
    if (!saw_stall) begin failures++; $display("FAIL starve_stall act=0 exp=1"); end
  endtask

  task automatic test_hazard();
    int gcyc = -1, vcyc = -1;
    logic [DW-1:0] vdata = '0;
    bit pend = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      drive_idle();
      if (cyc < 3) begin
        bus.dec_valid = 1'b1; bus.dec_wr_strb = '1;
        bus.dec_addr = (cyc == 1) ? AW'(3) : AW'(8'h20 + cyc);
        bus.dec_wr_data = (cyc == 1) ? DW'(32'h55) : DW'($urandom);
      end
      if (cyc == 2) pend = 1'b1;
      if (pend) begin bus.core_rd_en = 1'b1; bus.core_addr = AW'(3); end
      #1; exp_v = model_eval(); act_v = observed(); checks++;
      if (act_v !== exp_v) begin failures++; $display("FAIL hazard cyc=%0d act=%h exp=%h", cyc, act_v, exp_v); end
      if (bus.core_grant && gcyc < 0) gcyc = cyc;
      if (bus.core_rd_valid && vcyc < 0) begin vcyc = cyc; vdata = bus.core_rd_data; end
      if (e_win) pend = 1'b0;
      model_commit(); @(negedge clk);
    end
    checks++;
    if (gcyc != 3) begin failures++; $display("FAIL hazard_grant_cycle act=%0d exp=3", gcyc); end
    checks++;
    if (vcyc != 4) begin failures++; $display("FAIL hazard_valid_cycle act=%0d exp=4", vcyc); end
    checks++;
    if (vdata !== DW'(32'h55)) begin failures++; $display("FAIL hazard_data act=%h exp=55", vdata); end
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] d = DW'($urandom);
    bit pend = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      drive_idle();
      if (cyc == 0) begin
        bus.dec_valid = 1'b1; bus.dec_addr = AW'(7); bus.dec_wr_data = d; bus.dec_wr_strb = '1;
      end
      if (pend) begin
        bus.core_addr = AW'(7); bus.core_wr_data = ~d; bus.core_wr_strb = '1;
      end
      #1; exp_v = model_eval(); act_v = observed(); checks++;
      if (act_v !== exp_v) begin failures++; $display("FAIL same_cycle cyc=%0d act=%h exp=%h", cyc, act_v, exp_v); end
      if (e_win) pend = 1'b0;
      model_commit(); @(negedge clk);
    end
    checks++;
    if (ram[7] !== d) begin failures++; $display("FAIL same_cycle_final act=%h exp=%h", ram[7], d); end
  endtask

  task automatic test_zero_strb();
    int unsigned w0 = ram_writes;
    for (int cyc = 0; cyc < 6; cyc++) begin
      drive_idle();
      if (cyc < 4) begin
        bus.dec_valid = 1'b1; bus.dec_addr = AW'($urandom); bus.dec_wr_data = DW'($urandom);
      end
      #1; exp_v = model_eval(); act_v = observed(); checks++;
      if (act_v !== exp_v) begin failures++; $display("FAIL zero_strb cyc=%0d act=%h exp=%h", cyc, act_v, exp_v); end
      model_commit(); @(negedge clk);
    end
    checks++;
    if (ram_writes != w0) begin failures++; $display("FAIL zero_strb_writes act=%0d exp=%0d", ram_writes, w0); end
  endtask

  task automatic test_reset_mid();
    int unsigned w0 = ram_writes;
    for (int cyc = 0; cyc < 11; cyc++) begin
      drive_idle();
      rst = (cyc != 4);
      if (cyc < 5) begin bus.core_rd_en = 1'b1; bus.core_addr = AW'(12'h200); end
      if (cyc < 3) begin
        bus.dec_valid = 1'b1; bus.dec_addr = AW'(8'h30 + cyc);
        bus.dec_wr_data = DW'($urandom); bus.dec_wr_strb = '1;
      end
      #1; exp_v = model_eval(); act_v = observed(); checks++;
      if (act_v !== exp_v) begin failures++; $display("FAIL reset_mid cyc=%0d act=%h exp=%h", cyc, act_v, exp_v); end
      model_commit(); @(negedge clk);
    end
    checks++;
    if (ram_writes != w0) begin failures++; $display("FAIL reset_mid_writes act=%0d exp=%0d", ram_writes, w0); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ram[8'h30 + i] !== init_val(8'h30 + i)) begin
        failures++; $display("FAIL reset_mid_ram addr=%h act=%h exp=%h", 8'h30 + i, ram[8'h30 + i], init_val(8'h30 + i));
      end
    end
  endtask

  task automatic test_random();
    bit pend = 1'b0;
    for (int cyc = 0; cyc < 420; cyc++) begin
      rst = 1'b1;
      if (cyc < 400) begin
        if (!pend) begin
          bus.core_rd_en = 1'b0; bus.core_wr_strb = '0;
          if ($urandom_range(0, 3) != 0) begin
            pend = 1'b1;
            bus.core_addr = AW'($urandom_range(0, 15));
            bus.core_wr_data = DW'($urandom);
            case ($urandom_range(0, 2))
              0: bus.core_wr_strb = '0;
              1: bus.core_wr_strb = '1;
              default: bus.core_wr_strb = DW'($urandom);
            endcase
            bus.core_rd_en = (bus.core_wr_strb == '0) ? 1'b1 : 1'($urandom_range(0, 1));
          end
        end
        bus.dec_valid = 1'($urandom_range(0, 1));
        bus.dec_addr = AW'($urandom_range(0, 15));
        bus.dec_wr_data = DW'($urandom);
        case ($urandom_range(0, 2))
          0: bus.dec_wr_strb = '0;
          1: bus.dec_wr_strb = '1;
          default: bus.dec_wr_strb = DW'($urandom);
        endcase
        if ($urandom_range(0, 149) == 0) rst = 1'b0;
      end else begin
        drive_idle();
        pend = 1'b0;
      end
      #1; exp_v = model_eval(); act_v = observed(); checks++;
      if (act_v !== exp_v) begin failures++; $display("FAIL random cyc=%0d act=%h exp=%h", cyc, act_v, exp_v); end
      if (e_win || !rst) pend = 1'b0;
      model_commit(); @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = init_val(i);
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
    test_reset();
    test_fill();
    test_starvation();
    test_hazard();
    test_same_cycle();
    test_zero_strb();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
